// File: rtl/char_store.sv
// char_store: append-only character buffer for the password checker.
// Characters are appended in arrival order at index 'count'. Random-access
// reads return data one cycle after r_en. Only clear or reset frees space.
// Optional feature: define CHAR_STORE_VOWEL_CNT_EN to add the vowel_count
// port and a running count of stored ASCII vowels (DATA_W must be >= 8).
module char_store #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
`ifdef CHAR_STORE_VOWEL_CNT_EN
    ,
    output logic [ADDR_W:0]   vowel_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Full occupancy is exactly DEPTH, i.e. only the top bit of count set.
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              r_valid_q, r_valid_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              full_w;
    logic              wr_accept;
    logic              rd_hit;

`ifdef CHAR_STORE_VOWEL_CNT_EN
    logic [ADDR_W:0]   vowel_q, vowel_d;

    // Matches the ten ASCII vowels on the low byte of a character.
    function automatic logic is_vowel(input logic [7:0] c);
        case (c)
            8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
            8'h41, 8'h45, 8'h49, 8'h4F, 8'h55: is_vowel = 1'b1;
            default:                           is_vowel = 1'b0;
        endcase
    endfunction
`endif

    // Occupancy status, write acceptance and read hit are all derived from
    // the pre-edge count, so a same-cycle read never sees the slot being
    // written and a read during clear still sees the old contents.
    always_comb begin
        full_w    = (count_q == DEPTH_C);
        wr_accept = w_en & ~clear & ~full_w;
        rd_hit    = ({1'b0, r_addr} < count_q);
    end

    // Next-state for occupancy, the sticky overflow flag and the read port.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        r_valid_d  = r_en;
        r_data_d   = r_data_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (wr_accept) begin
            count_d = count_q + ONE_C;
        end else if (w_en) begin
            overflow_d = 1'b1;
        end
        if (r_en) begin
            r_data_d = rd_hit ? mem[r_addr] : '0;
        end
    end

`ifdef CHAR_STORE_VOWEL_CNT_EN
    // Vowel tally follows accepted appends only; dropped writes never count.
    always_comb begin
        vowel_d = vowel_q;
        if (clear) begin
            vowel_d = '0;
        end else if (wr_accept && is_vowel(w_data[7:0])) begin
            vowel_d = vowel_q + ONE_C;
        end
    end
`endif

    // Storage array: written at index count on an accepted append, never reset.
    always_ff @(posedge clock) begin
        if (wr_accept && !reset) begin
            mem[count_q[ADDR_W-1:0]] <= w_data;
        end
    end

    // State registers with synchronous reset; reset also kills an in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
        end
    end

`ifdef CHAR_STORE_VOWEL_CNT_EN
    // Vowel counter register, cleared alongside count.
    always_ff @(posedge clock) begin
        if (reset) begin
            vowel_q <= '0;
        end else begin
            vowel_q <= vowel_d;
        end
    end

    assign vowel_count = vowel_q;
`endif

    assign count    = count_q;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign w_ready  = ~full_w;
    assign overflow = overflow_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;

endmodule
